// File: rtl/systolic_mm_arbiter.sv
// Round-robin arbiter sharing one systolic matrix multiplier among NUM_REQ requesters,
// with a BUSY-cycle watchdog and a per-requester valid/ready result return.
module systolic_mm_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int M          = 8,
    parameter int N          = 8,
    parameter int P          = 8,
    parameter int NUM_REQ    = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*M*N*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*N*P*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]                resp_valid,
    input  logic [NUM_REQ-1:0]                resp_ready,
    output logic [M*P*DATA_WIDTH-1:0]         resp_c,
    output logic                              resp_err,
    output logic                              mm_start,
    output logic [M*N*DATA_WIDTH-1:0]         mm_a,
    output logic [N*P*DATA_WIDTH-1:0]         mm_b,
    input  logic                              mm_done,
    input  logic [M*P*DATA_WIDTH-1:0]         mm_c,
    output logic                              busy,
    output logic [15:0]                       last_latency
);
    localparam int AW = M * N * DATA_WIDTH;
    localparam int BW = N * P * DATA_WIDTH;
    localparam int CW = M * P * DATA_WIDTH;
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

    state_t          state_reg, state_next;
    logic [GW-1:0]   rr_ptr_reg;
    logic [GW-1:0]   grant_reg;
    logic [TW-1:0]   cnt_reg;
    logic [AW-1:0]   mm_a_reg;
    logic [BW-1:0]   mm_b_reg;
    logic [CW-1:0]   resp_c_reg;
    logic            resp_err_reg;
    logic [15:0]     last_latency_reg;

    logic            grant_valid;
    logic [GW-1:0]   grant_idx;
    int              idx;
    logic            timeout_hit;
    logic [31:0]     lat_calc;

    // Scan offsets from the top down so the smallest offset from rr_ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr_reg) + i) % NUM_REQ;
            if (req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = GW'(idx);
            end
        end
    end

    assign timeout_hit = (cnt_reg == TW'(TIMEOUT - 1));
    assign lat_calc    = 32'(cnt_reg) + 32'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (grant_valid) state_next = START;
            START: state_next = BUSY;
            BUSY:  if (mm_done || timeout_hit) state_next = RESP;
            RESP:  if (resp_ready[grant_reg]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_reg       <= '0;
            grant_reg        <= '0;
            cnt_reg          <= '0;
            mm_a_reg         <= '0;
            mm_b_reg         <= '0;
            resp_c_reg       <= '0;
            resp_err_reg     <= 1'b0;
            last_latency_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        grant_reg <= grant_idx;
                        mm_a_reg  <= req_a[grant_idx*AW +: AW];
                        mm_b_reg  <= req_b[grant_idx*BW +: BW];
                    end
                end
                START: cnt_reg <= '0;
                BUSY: begin
                    // A done arriving on the final watchdog cycle still counts as success.
                    if (mm_done) begin
                        resp_c_reg       <= mm_c;
                        resp_err_reg     <= 1'b0;
                        last_latency_reg <= (lat_calc > 32'h0000_FFFF) ? 16'hFFFF : lat_calc[15:0];
                    end else if (timeout_hit) begin
                        resp_c_reg   <= '0;
                        resp_err_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready[grant_reg])
                        rr_ptr_reg <= (grant_reg == GW'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Accept strobe is gated by reset so it reads 0 while reset is asserted.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_ready[gi]  = rst && (state_reg == IDLE) && grant_valid && (grant_idx == GW'(gi));
            assign resp_valid[gi] = (state_reg == RESP) && (grant_reg == GW'(gi));
        end
    endgenerate

    assign mm_start     = (state_reg == START);
    assign busy         = (state_reg != IDLE);
    assign mm_a         = mm_a_reg;
    assign mm_b         = mm_b_reg;
    assign resp_c       = resp_c_reg;
    assign resp_err     = resp_err_reg;
    assign last_latency = last_latency_reg;
endmodule

// File: tb/tb_systolic_mm_arbiter.sv
// Directed bench for systolic_mm_arbiter: table of jobs plus reset corner sequences.
module tb_systolic_mm_arbiter;
    localparam int DW = 8, M = 8, N = 8, P = 8, NR = 2, TO = 16;
    localparam int AW = M * N * DW, BW = N * P * DW, CW = M * P * DW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_a;
    logic [NR*BW-1:0]  req_b;
    logic [NR-1:0]     resp_valid;
    logic [NR-1:0]     resp_ready = '0;
    logic [CW-1:0]     resp_c;
    logic              resp_err;
    logic              mm_start;
    logic [AW-1:0]     mm_a;
    logic [BW-1:0]     mm_b;
    logic              mm_done = 1'b0;
    logic [CW-1:0]     mm_c;
    logic              busy;
    logic [15:0]       last_latency;

    int errors = 0;
    int checks = 0;

    systolic_mm_arbiter #(
        .DATA_WIDTH(DW), .M(M), .N(N), .P(P), .NUM_REQ(NR), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_c(resp_c), .resp_err(resp_err),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_done(mm_done), .mm_c(mm_c),
        .busy(busy), .last_latency(last_latency)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] mask;
        int            lat;      // BUSY cycles until done; 0 = never (timeout)
        int            grant;
        logic          err;
        logic [15:0]   last_lat;
        int            hold;     // cycles resp_ready is withheld
    } vec_t;

    vec_t tbl[8];

    function automatic logic [AW-1:0] ident();
        logic [AW-1:0] v = '0;
        for (int i = 0; i < M; i++) v[(i*N+i)*DW +: DW] = 8'd1;
        return v;
    endfunction

    function automatic logic [BW-1:0] bmat(int r);
        logic [BW-1:0] v = '0;
        for (int k = 0; k < N; k++)
            for (int j = 0; j < P; j++)
                v[(k*P+j)*DW +: DW] = 8'(k*8 + j + r*64);
        return v;
    endfunction

    // Behavioural stand-in for the multiplier's result_c.
    function automatic logic [CW-1:0] matmul(logic [AW-1:0] a, logic [BW-1:0] b);
        logic [CW-1:0] c = '0;
        int acc;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < P; j++) begin
                acc = 0;
                for (int k = 0; k < N; k++)
                    acc += int'($signed(a[(i*N+k)*DW +: DW])) * int'($signed(b[(k*P+j)*DW +: DW]));
                c[(i*P+j)*DW +: DW] = 8'(acc);
            end
        return c;
    endfunction

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v);
        int n;
        logic [CW-1:0] exp_c;
        logic [CW-1:0] held_c;
        logic [NR-1:0] held_v;
        req_valid = v.mask;
        #1;
        n = 0;
        while (req_ready == '0 && n < 10) begin
            @(negedge clk); #1; n++;
        end
        chk("req_ready", CW'(req_ready), CW'(1 << v.grant));
        if (req_ready == '0) return;
        @(negedge clk);
        chk("mm_start_hi", CW'(mm_start), CW'(1));
        chk("mm_a", CW'(mm_a), CW'(ident()));
        chk("mm_b", CW'(mm_b), CW'(bmat(v.grant)));
        chk("ready_in_start", CW'(req_ready), CW'(0));
        @(negedge clk);
        chk("mm_start_lo", CW'(mm_start), CW'(0));
        n = 0;
        while (resp_valid == '0 && n < TO + 20) begin
            if (v.lat > 0 && n == v.lat - 1) begin
                mm_done = 1'b1;
                mm_c    = matmul(mm_a, mm_b);
            end
            @(negedge clk);
            mm_done = 1'b0;
            mm_c    = {(CW/8){8'h5A}};
            n++;
        end
        exp_c = v.err ? '0 : CW'(bmat(v.grant));
        chk("resp_delay", CW'(n), CW'((v.lat > 0) ? v.lat : TO));
        chk("resp_valid", CW'(resp_valid), CW'(1 << v.grant));
        chk("resp_err", CW'(resp_err), CW'(v.err));
        chk("resp_c", resp_c, exp_c);
        chk("last_latency", CW'(last_latency), CW'(v.last_lat));
        held_c = resp_c;
        held_v = resp_valid;
        for (int h = 0; h < v.hold; h++) begin
            mm_done = 1'b1;   // must be ignored outside BUSY
            @(negedge clk);
            chk("bp_valid", CW'(resp_valid), CW'(held_v));
            chk("bp_c", resp_c, held_c);
            chk("bp_ready", CW'(req_ready), CW'(0));
            chk("bp_busy", CW'(busy), CW'(1));
        end
        mm_done = 1'b0;
        resp_ready = NR'(1 << v.grant);
        @(negedge clk);
        resp_ready = '0;
        req_valid  = '0;
        $display("job grant=%0d lat=%0d err=%0b last_latency=%0d", v.grant, v.lat, resp_err, last_latency);
        chk("resp_done", CW'(resp_valid), CW'(0));
        chk("idle_busy", CW'(busy), CW'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, CW'(busy), CW'(0));
        chk({tag, "_req_ready"}, CW'(req_ready), CW'(0));
        chk({tag, "_resp_valid"}, CW'(resp_valid), CW'(0));
        chk({tag, "_mm_start"}, CW'(mm_start), CW'(0));
        chk({tag, "_resp_err"}, CW'(resp_err), CW'(0));
        chk({tag, "_resp_c"}, resp_c, CW'(0));
        chk({tag, "_mm_a"}, CW'(mm_a), CW'(0));
        chk({tag, "_mm_b"}, CW'(mm_b), CW'(0));
        chk({tag, "_last_latency"}, CW'(last_latency), CW'(0));
    endtask

    initial begin
        tbl[0] = '{2'b01,  5, 0, 1'b0, 16'd5,  0};  // single job
        tbl[1] = '{2'b11,  3, 1, 1'b0, 16'd3,  0};  // round-robin 0,1,0,1
        tbl[2] = '{2'b11,  7, 0, 1'b0, 16'd7,  0};
        tbl[3] = '{2'b11,  2, 1, 1'b0, 16'd2, 20};  // backpressure on r1
        tbl[4] = '{2'b10,  4, 1, 1'b0, 16'd4,  0};
        tbl[5] = '{2'b01,  0, 0, 1'b1, 16'd4,  0};  // timeout, latency kept
        tbl[6] = '{2'b01, 16, 0, 1'b0, 16'd16, 0};  // done on the last watchdog cycle
        tbl[7] = '{2'b01,  1, 0, 1'b0, 16'd1,  0};

        for (int r = 0; r < NR; r++) begin
            req_a[r*AW +: AW] = ident();
            req_b[r*BW +: BW] = bmat(r);
        end
        mm_c = {(CW/8){8'h5A}};
        req_valid = 2'b11;
        #12;
        chk_reset_outputs("rst0");
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_job(tbl[i]);

        // Reset mid-BUSY with rr_ptr=1: job aborts, next grant returns to r0.
        req_valid = 2'b11;
        #1;
        chk("pre_rst_grant", CW'(req_ready), CW'(2'b10));
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", CW'(busy), CW'(1));
        #1 rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b1;
        run_job('{2'b11, 2, 0, 1'b0, 16'd2, 0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end
endmodule
